// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//
// ID -> EX pipeline register for the RV32I 5-stage core. Carries the source
// and destination register indices, write-enable / load control bits and an
// opaque payload (immediate, PC, ...) from decode into execute.
//
// Besides plain staging it:
//   - tracks a valid bit for the instruction held in EX,
//   - remembers a flush that arrives while the stage is stalled and turns it
//     into a bubble on the first unstalled edge,
//   - never propagates a write to x0,
//   - flags load-use hazards combinationally for the hazard unit,
//   - counts (saturating) the cycles a valid instruction sat stalled in EX.
//
// Ports
//   clk                clock, all state changes on the rising edge
//   rst_n              synchronous active-low reset
//   stall_i            hold EX contents this edge
//   flush_i            kill the instruction entering EX
//   id_valid_i         ID holds a real instruction
//   id_src_i           NUM_SRC packed source indices, field k at [k*REG_AW +: REG_AW]
//   id_dest_i          destination index
//   id_we_i            instruction writes the register file
//   id_is_load_i       instruction is a load
//   id_payload_i       opaque payload
//   ex_*_o             registered EX copies of the ID fields
//   load_use_hazard_o  combinational load-use hazard
//   flush_pending_o    a flush was seen during a stall and is not yet consumed
//   stall_cnt_o        saturating count of stalled cycles with a valid EX
//
// Control semantics (one rule, applied every rising edge, highest first):
//   reset  : every register and the pending flag go to 0
//   stall  : EX registers hold; a flush seen now is latched as pending
//   flush  : (flush_i or pending) -> EX loads all-zero bubble, pending clears
//   load   : EX captures the ID fields
// There is no backpressure beyond stall_i: when stall_i is low the stage
// always advances.
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = 64,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
    input  logic [REG_AW-1:0]         id_dest_i,
    input  logic                      id_we_i,
    input  logic                      id_is_load_i,
    input  logic [DATA_W-1:0]         id_payload_i,
    output logic                      ex_valid_o,
    output logic [NUM_SRC*REG_AW-1:0] ex_src_o,
    output logic [REG_AW-1:0]         ex_dest_o,
    output logic                      ex_we_o,
    output logic                      ex_is_load_o,
    output logic [DATA_W-1:0]         ex_payload_o,
    output logic                      load_use_hazard_o,
    output logic                      flush_pending_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    localparam int SRC_W = NUM_SRC * REG_AW;

    // A pending flush is honoured exactly like a fresh one, and both together
    // still only produce a single bubble.
    logic do_flush;
    assign do_flush = flush_i | flush_pending_o;

    // x0 is hard-wired zero, so a write to it is dropped here rather than
    // letting forwarding logic downstream see a bogus producer.
    logic dest_nonzero;
    assign dest_nonzero = (id_dest_i != '0);

    // -----------------------------------------------------------------------
    // EX staging registers and pending-flush flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_o      <= 1'b0;
            ex_src_o        <= '0;
            ex_dest_o       <= '0;
            ex_we_o         <= 1'b0;
            ex_is_load_o    <= 1'b0;
            ex_payload_o    <= '0;
            flush_pending_o <= 1'b0;
        end else if (stall_i) begin
            // Contents hold; only remember a flush so it is not lost.
            if (flush_i) begin
                flush_pending_o <= 1'b1;
            end
        end else if (do_flush) begin
            ex_valid_o      <= 1'b0;
            ex_src_o        <= '0;
            ex_dest_o       <= '0;
            ex_we_o         <= 1'b0;
            ex_is_load_o    <= 1'b0;
            ex_payload_o    <= '0;
            flush_pending_o <= 1'b0;
        end else begin
            ex_valid_o   <= id_valid_i;
            ex_src_o     <= id_src_i;
            ex_dest_o    <= id_dest_i;
            ex_we_o      <= id_we_i & id_valid_i & dest_nonzero;
            ex_is_load_o <= id_is_load_i & id_valid_i;
            ex_payload_o <= id_payload_i;
        end
    end

    // -----------------------------------------------------------------------
    // Stall counter: counts edges where a real instruction is held in EX.
    // Saturates so a long stall can never read back as a small number.
    // -----------------------------------------------------------------------
    logic cnt_at_max;
    assign cnt_at_max = (stall_cnt_o == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (stall_i && ex_valid_o && !cnt_at_max) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Load-use hazard: the load in EX produces its value too late for the
    // instruction in ID if any of that instruction's sources name it.
    // Deliberately not gated by stall_i so the hazard unit sees it while it
    // is holding the pipeline.
    // -----------------------------------------------------------------------
    logic [NUM_SRC-1:0] src_match;

    always_comb begin
        src_match = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_match[k] = (id_src_i[k*REG_AW +: REG_AW] == ex_dest_o);
        end
    end

    logic ex_is_producing_load;
    assign ex_is_producing_load = ex_valid_o & ex_is_load_o & ex_we_o;

    assign load_use_hazard_o = ex_is_producing_load & id_valid_i & (|src_match);

    // Unused-width guard: keeps SRC_W referenced for readers of the packing.
    logic [SRC_W-1:0] src_width_ref;
    assign src_width_ref = ex_src_o;
    logic unused_ok;
    assign unused_ok = &{1'b0, src_width_ref};

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID→EX pipeline register for the RV32I 5-stage core. It carries the register-index fields, control bits and an opaque payload from decode into execute, with stall (bubble) and flush control. Unlike the fixed 5-bit index register it replaces, it adds a valid bit, remembers a flush raised during a stall, suppresses x0 writes, detects load-use hazards and counts stall cycles. It sits between the decode stage and the EX datapath; the hazard unit drives `stall_i` and `flush_i`.

## Interface
Parameters:
- `REG_AW`, 5: register-index width.
- `NUM_SRC`, 2: number of source-register fields.
- `DATA_W`, 64: payload width, carried opaquely (immediate, PC and similar).
- `CNT_W`, 16: stall-counter width.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `stall_i`  in  1  bubble; EX contents hold.
- `flush_i`  in  1  kill the instruction entering EX.
- `id_valid_i`  in  1  ID holds a real instruction.
- `id_src_i`  in  NUM_SRC*REG_AW  source indices; field k = bits [k*REG_AW +: REG_AW].
- `id_dest_i`  in  REG_AW  destination index.
- `id_we_i`  in  1  instruction writes the register file.
- `id_is_load_i`  in  1  instruction is a load.
- `id_payload_i`  in  DATA_W  opaque payload.
- `ex_valid_o`, `ex_src_o`, `ex_dest_o`, `ex_we_o`, `ex_is_load_o`, `ex_payload_o`  out  (widths as the inputs)  registered EX copies.
- `load_use_hazard_o`  out  1  combinational load-use hazard.
- `flush_pending_o`  out  1  a flush is latched during a stall.
- `stall_cnt_o`  out  CNT_W  saturating count of stalled valid cycles.

## Operation
- Update priority each edge, highest first: reset, stall, flush, load.
- Reset (`rst_n`=0):
  - All outputs go to 0, `flush_pending_o` is cleared and `stall_cnt_o` is cleared.
  - Reset overrides stall and flush in the same cycle.
- Stall (`stall_i`=1):
  - All EX registers hold their values.
  - If `flush_i`=1, `flush_pending_o` is set to 1. It stays set until consumed.
- Flush (`stall_i`=0 and (`flush_i`=1 or `flush_pending_o`=1)):
  - All EX registers load 0, which forms a bubble (`ex_valid_o`=0).
  - `flush_pending_o` is cleared.
- Load (`stall_i`=0, no flush):
  - All fields are copied from the ID inputs. `ex_valid_o` takes `id_valid_i`.
  - `ex_we_o` takes `id_we_i & id_valid_i & (id_dest_i != 0)`. An x0 write is never propagated.
  - `ex_is_load_o` takes `id_is_load_i & id_valid_i`.
- `load_use_hazard_o` is asserted when all of the following hold:
  - `ex_valid_o`, `ex_is_load_o` and `ex_we_o` are 1;
  - `id_valid_i` is 1;
  - at least one source field k has `id_src_i` field k == `ex_dest_o`.
  - It is purely combinational and is not gated by `stall_i`.
- Stall counter:
  - Increments by 1 on every edge with `stall_i`=1 and `ex_valid_o`=1.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - Cleared only by reset.

## Timing
- Latency: ID inputs appear on the EX outputs 1 cycle later, when the stage is neither stalled nor flushed.
- A stall is honoured in the cycle it is asserted. Consecutive stall cycles hold the stage indefinitely.
- Simultaneous `stall_i`=1 and `flush_i`=1: the stage holds and the flush is latched. The bubble is inserted on the first edge where `stall_i`=0.
- Several flushes during one stall collapse into a single pending flush.
- A pending flush and a fresh `flush_i` on the release edge together produce one bubble.
- `rst_n` deasserting mid-stall: the stage is already zeroed, the pending flag is 0 and operation resumes normally.
- All outputs are registered except `load_use_hazard_o`. Its path is EX registers plus ID inputs to output, through NUM_SRC comparators.

## Test plan
1. Reset then pass-through: hold `rst_n`=0 for 2 cycles and check all outputs are 0. Then drive `id_src_i`={5'd2,5'd1}, `id_dest_i`=3, `id_we_i`=1, `id_payload_i`=64'hDEAD_BEEF, `id_valid_i`=1. On the next edge the EX outputs must match, with `ex_we_o`=1 and `ex_valid_o`=1.
2. x0 suppression: drive `id_dest_i`=0, `id_we_i`=1, `id_valid_i`=1. After one edge, `ex_we_o`=0, `ex_dest_o`=0 and `ex_valid_o`=1.
3. Stall with latched flush:
   - Load dest=7 into EX.
   - Assert `stall_i`=1 for 3 cycles, with `flush_i`=1 in the second cycle only.
   - During the stall, EX holds dest=7 and `flush_pending_o` reads 1 from the third cycle.
   - On release, the next edge gives `ex_valid_o`=0 and `flush_pending_o`=0.
   - `stall_cnt_o` reads 3.
4. Load-use hazard:
   - EX holds a valid load with dest=5 and `ex_we_o`=1; ID presents `id_src_i`={5'd0,5'd5} with `id_valid_i`=1. Expect `load_use_hazard_o`=1.
   - Changing the sources to {5'd4,5'd6} gives 0.
   - The same match with EX as a non-load gives 0.
5. Reset mid-stall: assert `stall_i`=1 and `flush_i`=1, then `rst_n`=0 for 1 cycle. Expect all outputs 0, `flush_pending_o`=0 and `stall_cnt_o`=0. Normal loading resumes on the first edge with `rst_n`=1 and `stall_i`=0.
6. Counter saturation: with CNT_W=4 and a valid EX, stall for 20 cycles. `stall_cnt_o` must stop at 15 and never wrap to 0.
